// File: rtl/rv32i_pkg.sv
// Shared constants and types for the rv32i writeback / register file slice.
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_t;
endpackage

// File: rtl/rv32i_wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback,
// plus the read-after-write and write-after-write hazard detection that drives stall.
module rv32i_wb_scoreboard
  import rv32i_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          ready,
  input  logic          pen,
  input  logic [AW-1:0] rad,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_rad,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          ra1_en,
  input  logic          ra2_en,
  output logic          stall
);
  logic [NREG-1:0] pend_q, pend_d;
  logic            hz_r1, hz_r2, hz_waw;

  // A writeback landing this cycle resolves the hazard through the bypass path.
  always_comb begin
    hz_r1  = ra1_en && pend_q[ra1] && !(pen && (rad == ra1));
    hz_r2  = ra2_en && pend_q[ra2] && !(pen && (rad == ra2));
    hz_waw = iss_en && pend_q[iss_rad] && !(pen && (rad == iss_rad));
    stall  = !ready || hz_r1 || hz_r2 || hz_waw;
  end

  // Set beats clear when issue and writeback target the same register.
  always_comb begin
    pend_d    = pend_q;
    pend_d[0] = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      pend_d[i] = (iss_en && !stall && (iss_rad == AW'(i))) ||
                  (pend_q[i] && !(ready && pen && (rad == AW'(i))));
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
endmodule

// File: rtl/rv32i_regfile_wb.sv
// Writeback register file: post-reset zeroing sweep, storage array, two registered
// read ports with same-cycle writeback bypass, and the decode stall from the scoreboard.
module rv32i_regfile_wb
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            pen,
  input  logic [AW-1:0]   rad,
  input  logic            rad_zero,
  input  logic [XLEN-1:0] rdd,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rad,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic            ra1_en,
  input  logic            ra2_en,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            stall,
  output logic            ready
);
  wb_state_t       state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic            wr;
  xword_t          regs [NREG];

  assign wr = (state_q == RUN) && pen && !rad_zero && (rad != {AW{1'b0}});

  // Sweep sequencing: leave INIT once the last register has been zeroed.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(NREG - 1)) begin
          state_d = RUN;
        end else begin
          state_d = INIT;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
    ready_d = (state_d == RUN);
  end

  // x0 reads zero; a write to the same address this cycle is forwarded.
  always_comb begin
    if (state_q != RUN || ra1 == {AW{1'b0}}) begin
      rd1_d = {XLEN{1'b0}};
    end else if (wr && rad == ra1) begin
      rd1_d = rdd;
    end else begin
      rd1_d = regs[ra1];
    end
    if (state_q != RUN || ra2 == {AW{1'b0}}) begin
      rd2_d = {XLEN{1'b0}};
    end else if (wr && rad == ra2) begin
      rd2_d = rdd;
    end else begin
      rd2_d = regs[ra2];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= INIT;
      init_cnt_q <= AW'(1);
      ready_q    <= 1'b0;
      rd1_q      <= {XLEN{1'b0}};
      rd2_q      <= {XLEN{1'b0}};
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
    end
  end

  // Storage is not reset; the sweep zeroes it before ready is raised.
  always_ff @(posedge clk) begin
    if (!clr && state_q == INIT) begin
      regs[init_cnt_q] <= {XLEN{1'b0}};
    end else if (!clr && wr) begin
      regs[rad] <= rdd;
    end
  end

  rv32i_wb_scoreboard u_sb (
    .clk     (clk),
    .clr     (clr),
    .ready   (ready_q),
    .pen     (pen),
    .rad     (rad),
    .iss_en  (iss_en),
    .iss_rad (iss_rad),
    .ra1     (ra1),
    .ra2     (ra2),
    .ra1_en  (ra1_en),
    .ra2_en  (ra2_en),
    .stall   (stall)
  );

  assign rd1   = rd1_q;
  assign rd2   = rd2_q;
  assign ready = ready_q;
endmodule
